adc_req_scheduler: RTL and testbench
====================================

Name: adc_req_scheduler

Overview:
- Shares one AD7908-style SPI conversion engine between NREQ requesters: joystick/dial, CdS light sensor, and spare inputs.
- Each requester asks for one channel at a time. The block arbitrates requests round-robin and drives one engine frame per grant.
- It tracks the ADC's one-frame result pipeline: the data shifted out in frame k belongs to the address programmed in frame k-1. Each result is returned to the requester that owns it.
- Sits between the application FSMs and the SPI frame engine.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CH_W, 3, channel address width.
- DATA_W, 8, result width delivered by the engine.
- TIMEOUT_CYC, 400000, max clk cycles from eng_start to eng_done. Used only with ADC_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request. Held with req_chan stable until accepted.
- req_chan  in  NREQ*CH_W  requested channel; slice i belongs to requester i.
- req_ready  out  NREQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NREQ  one-hot, one-cycle result pulse.
- rsp_data  out  DATA_W  result; valid while any rsp_valid bit is high.
- rsp_chan  out  CH_W  channel of rsp_data.
- eng_start  out  1  one-cycle frame start to the engine.
- eng_addr  out  CH_W  address the engine programs in this frame. Held from eng_start to eng_done.
- eng_busy  in  1  engine frame in progress.
- eng_done  in  1  one-cycle pulse at end of frame.
- eng_rdata  in  DATA_W  data shifted out in the finished frame. Valid with eng_done.
- err_timeout  out  1  one-cycle pulse on an aborted frame. Tied 0 when the feature is off.

Behaviour:
- Reset: asynchronous, active-high, on rst. The engine shares rst.
  - All outputs go to 0; state = IDLE; rr_ptr = 0; inflight invalid.
- In-flight register: {inf_valid, inf_owner, inf_chan}. It records which requester owns the data that the next finished frame returns.
- IDLE:
  - Go to ISSUE if any req_valid is high or inf_valid = 1.
  - Otherwise stay; eng_start stays 0.
- ISSUE:
  - Waits while eng_busy = 1.
  - With eng_busy = 0 and any req_valid high: pick winner w.
    - Search starts at rr_ptr, wrap-around modulo NREQ.
    - Assert req_ready[w] and eng_start for that cycle.
    - eng_addr <= chan_w; nxt_inf <= {1, w, chan_w}; rr_ptr <= (w+1) mod NREQ. Go to WAIT.
  - With no req_valid and inf_valid = 1: flush frame.
    - eng_start = 1; eng_addr <= inf_chan; nxt_inf <= invalid. Go to WAIT.
- WAIT:
  - On eng_done, the following cycle:
    - If inf_valid: rsp_valid[inf_owner] = 1, rsp_data = eng_rdata (captured), rsp_chan = inf_chan.
    - If inf_valid = 0: eng_rdata is discarded.
    - inf <= nxt_inf; state -> IDLE.
- Latency: a result arrives after two frames, either its own plus the next grant, or its own plus a flush. Back-to-back requests keep the pipeline full with no flush frames.
- Boundary conditions:
  - First frame after reset: its data is discarded.
  - req_valid dropping before accept is a protocol violation; no requirement.
  - A new req_valid in the same cycle as eng_done waits for the next ISSUE.
  - The same requester may be granted again only after its rsp_valid. Its req_valid is masked while it owns inf or nxt_inf.
  - rst mid-frame abandons the frame; no rsp is issued.
  - eng_done outside WAIT is ignored.
- rsp_valid and req_ready are never high for more than one cycle. At most one bit of each is set.

Optional Feature:
- Macro ADC_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT. Reaching TIMEOUT_CYC without eng_done causes:
    - a one-cycle err_timeout pulse;
    - inf and nxt_inf invalidated, so both affected requesters get no rsp and must re-request;
    - state -> IDLE.
- Undefined:
  - No counter; err_timeout is constant 0.
  - WAIT lasts until eng_done.

Test Plan:
- Single request: req_valid[1] = 1, chan 2.
  - Expect req_ready[1] pulse and eng_start with eng_addr = 2.
  - Frame 1 eng_rdata = 0x00 is discarded.
  - A flush frame follows with eng_addr = 2; its eng_rdata = 0xA5 gives rsp_valid[1], rsp_data = 0xA5, rsp_chan = 2.
- Round-robin: all four req_valid held high with different channels.
  - Grant order 0,1,2,3.
  - Each rsp arrives one frame after the next grant. Requester 3's rsp follows a flush.
- Pointer wrap: after a grant to 3, requesters 0 and 2 request together. Expect grant to 0 first, then 2.
- Back-to-back: requesters 0 and 1 request continuously.
  - No flush frames.
  - Each eng_done (except the first after reset) produces exactly one rsp_valid.
  - rsp_data matches the previous frame's address.
- Reset mid-WAIT: assert rst during a frame. Expect all outputs 0, no rsp_valid, and the next request behaves as the first after reset.
- ADC_SCHED_TIMEOUT_EN with TIMEOUT_CYC = 50: withhold eng_done.
  - Expect err_timeout at cycle 50 of WAIT and return to IDLE.
  - A later request completes normally.

Source files
------------

// File: rtl/adc_req_scheduler.sv
// rtl/adc_req_scheduler.sv - round-robin scheduler for a shared SPI ADC engine with a one-frame result pipeline
// Optional stuck-frame abort is enabled by defining ADC_SCHED_TIMEOUT_EN.
module adc_req_scheduler #(
    parameter int NREQ        = 4,
    parameter int CH_W        = 3,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 400000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*CH_W-1:0] req_chan,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DATA_W-1:0]    rsp_data,
    output logic [CH_W-1:0]      rsp_chan,
    output logic                 eng_start,
    output logic [CH_W-1:0]      eng_addr,
    input  logic                 eng_busy,
    input  logic                 eng_done,
    input  logic [DATA_W-1:0]    eng_rdata,
    output logic                 err_timeout
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        state;
    logic [OW-1:0]     rr_ptr;
    logic              inf_valid, nxt_valid;
    logic [OW-1:0]     inf_owner, nxt_owner;
    logic [CH_W-1:0]   inf_chan, nxt_chan;

    logic [NREQ-1:0]   owned, eligible;
    logic [2*NREQ-1:0] rotated;
    logic              found;
    logic [OW:0]       win_sum;
    logic [OW-1:0]     win, win_next;
    logic [CH_W-1:0]   win_chan;

    // A requester whose result is still in the pipeline must not be granted again.
    always_comb begin
        owned = '0;
        if (inf_valid) owned[inf_owner] = 1'b1;
        if (nxt_valid) owned[nxt_owner] = 1'b1;
    end

    assign eligible = req_valid & ~owned;
    assign rotated  = {eligible, eligible} >> rr_ptr;

    always_comb begin
        found   = 1'b0;
        win_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found   = 1'b1;
                win_sum = {1'b0, rr_ptr} + (OW+1)'(k);
            end
        end
        win      = (win_sum >= (OW+1)'(NREQ)) ? OW'(win_sum - (OW+1)'(NREQ)) : win_sum[OW-1:0];
        win_next = (win == OW'(NREQ - 1)) ? '0 : win + OW'(1);
    end

    always_comb begin
        win_chan = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == OW'(i)) win_chan = req_chan[i*CH_W +: CH_W];
        end
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;
    logic          timed_out;
    assign timed_out = (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign err_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            inf_valid <= 1'b0;
            inf_owner <= '0;
            inf_chan  <= '0;
            nxt_valid <= 1'b0;
            nxt_owner <= '0;
            nxt_chan  <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_chan  <= '0;
            eng_start <= 1'b0;
            eng_addr  <= '0;
`ifdef ADC_SCHED_TIMEOUT_EN
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            eng_start <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (|req_valid || inf_valid) state <= S_ISSUE;
                end
                S_ISSUE: begin
`ifdef ADC_SCHED_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (!eng_busy) begin
                        if (found) begin
                            req_ready <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                            eng_start <= 1'b1;
                            eng_addr  <= win_chan;
                            nxt_valid <= 1'b1;
                            nxt_owner <= win;
                            nxt_chan  <= win_chan;
                            rr_ptr    <= win_next;
                            state     <= S_WAIT;
                        end else if (inf_valid) begin
                            // Flush: re-run the pending address just to clock out its result.
                            eng_start <= 1'b1;
                            eng_addr  <= inf_chan;
                            nxt_valid <= 1'b0;
                            state     <= S_WAIT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    if (eng_done) begin
                        if (inf_valid) begin
                            rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << inf_owner;
                            rsp_data  <= eng_rdata;
                            rsp_chan  <= inf_chan;
                        end
                        inf_valid <= nxt_valid;
                        inf_owner <= nxt_owner;
                        inf_chan  <= nxt_chan;
                        state     <= S_IDLE;
                    end
`ifdef ADC_SCHED_TIMEOUT_EN
                    else if (timed_out) begin
                        err_timeout <= 1'b1;
                        inf_valid   <= 1'b0;
                        nxt_valid   <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_req_scheduler.sv
// tb/tb_adc_req_scheduler.sv - self-checking bench for adc_req_scheduler with a pipelined ADC engine model
module tb_adc_req_scheduler;
    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_chan;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [2:0]  rsp_chan;
    logic        eng_start;
    logic [2:0]  eng_addr;
    logic        eng_busy;
    logic        eng_done;
    logic [7:0]  eng_rdata;
    logic        err_timeout;

    adc_req_scheduler #(.NREQ(4), .CH_W(3), .DATA_W(8), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_chan(req_chan), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_chan(rsp_chan),
        .eng_start(eng_start), .eng_addr(eng_addr),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_rdata(eng_rdata),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [11:0] chans;
        int          n;
        logic [15:0] order;
        int          frames;
    } vec_t;
    vec_t vecs [6];

    int n_pass = 0;
    int n_chk  = 0;

    logic [7:0] adc_val [8];
    logic [2:0] chan_of [4];
    logic [2:0] exp_chan [4];
    logic [3:0] outstanding;
    logic [3:0] elig_prev;
    logic [1:0] mdl_ptr;
    int grant_log[$];
    int rsp_log[$];
    int n_frames, n_flush, n_rsp, n_err, n_dropped;
    logic [2:0] last_flush_addr, last_rsp_chan;
    logic [7:0] last_rsp_data;
    bit rand_mode, cont_mode, hold_done;
    logic [3:0] cont_mask;
    int e_left;
    logic [2:0] e_addr, e_prev;
    bit e_prev_v;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [1:0] idx_of(logic [3:0] v);
        idx_of = 2'd0;
        for (int i = 3; i >= 0; i--) if (v[i[1:0]]) idx_of = i[1:0];
    endfunction

    function automatic int rr_pick(logic [3:0] e, logic [1:0] p);
        logic [1:0] j;
        for (int k = 0; k < 4; k++) begin
            j = p + k[1:0];
            if (e[j]) return int'(j);
        end
        return -1;
    endfunction

    function automatic int qat(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic set_chan(logic [1:0] i, logic [2:0] c);
        chan_of[i] = c;
        req_chan   = {chan_of[3], chan_of[2], chan_of[1], chan_of[0]};
    endtask

    task automatic upd_elig();
        elig_prev = req_valid & ~outstanding;
    endtask

    // Scoreboard: each accepted request must come back exactly once, to its owner, with the
    // ADC value of the channel it asked for.
    task automatic monitor();
        logic [1:0] w;
        if (req_ready != 4'b0) begin
            w = idx_of(req_ready);
            check("req_ready_onehot", $countones(req_ready), 1);
            check("grant_rr", 32'(w), rr_pick(elig_prev, mdl_ptr));
            check("grant_start", 32'(eng_start), 1);
            check("grant_addr", 32'(eng_addr), 32'(chan_of[w]));
            check("grant_not_owned", 32'(outstanding[w]), 0);
            outstanding[w] = 1'b1;
            exp_chan[w]    = chan_of[w];
            mdl_ptr        = w + 2'd1;
            grant_log.push_back(int'(w));
            req_valid[w]   = 1'b0;
        end else if (eng_start) begin
            n_flush++;
            last_flush_addr = eng_addr;
            check("flush_has_owner", 32'(outstanding != 4'b0), 1);
        end
        if (eng_start) n_frames++;
        if (rsp_valid != 4'b0) begin
            w = idx_of(rsp_valid);
            check("rsp_valid_onehot", $countones(rsp_valid), 1);
            check("rsp_owner", 32'(outstanding[w]), 1);
            check("rsp_chan", 32'(rsp_chan), 32'(exp_chan[w]));
            check("rsp_data", 32'(rsp_data), 32'(adc_val[exp_chan[w]]));
            outstanding[w] = 1'b0;
            last_rsp_data  = rsp_data;
            last_rsp_chan  = rsp_chan;
            rsp_log.push_back(int'(w));
            n_rsp++;
        end
        if (err_timeout) begin
            n_err++;
            n_dropped  += $countones(outstanding);
            outstanding = 4'b0;
        end
    endtask

    // ADC engine model: data shifted out in a frame belongs to the previous frame's address.
    task automatic engine();
        if (rst) begin
            eng_busy = 1'b0; eng_done = 1'b0; e_prev_v = 1'b0;
            return;
        end
        eng_done  = 1'b0;
        eng_rdata = 8'($urandom);
        if (eng_start) begin
            eng_busy = 1'b1;
            e_addr   = eng_addr;
            e_left   = int'($urandom_range(1, 4));
        end else if (eng_busy && !hold_done) begin
            e_left--;
            if (e_left == 0) begin
                eng_busy  = 1'b0;
                eng_done  = 1'b1;
                eng_rdata = e_prev_v ? adc_val[e_prev] : 8'h00;
                check("eng_addr_held", 32'(eng_addr), 32'(e_addr));
                e_prev   = e_addr;
                e_prev_v = 1'b1;
            end
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (!req_valid[i[1:0]] &&
                ((rand_mode && $urandom_range(0, 3) == 0) || (cont_mode && cont_mask[i[1:0]]))) begin
                set_chan(i[1:0], 3'($urandom));
                req_valid[i[1:0]] = 1'b1;
            end
        end
        upd_elig();
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) monitor();
        engine();
        drive();
    endtask

    task automatic drain(int bound);
        int g = 0;
        while ((outstanding != 4'b0 || req_valid != 4'b0) && g < bound) begin
            tick();
            g++;
        end
        check("drain_done", {24'b0, outstanding, req_valid}, 0);
    endtask

    initial begin
        int g0, r0, f0, fl0, g;
        rst = 1'b0; req_valid = 4'b0; req_chan = '0;
        eng_busy = 1'b0; eng_done = 1'b0; eng_rdata = '0;
        outstanding = 4'b0; elig_prev = 4'b0; mdl_ptr = 2'd0;
        n_frames = 0; n_flush = 0; n_rsp = 0; n_err = 0; n_dropped = 0;
        rand_mode = 0; cont_mode = 0; hold_done = 0; cont_mask = 4'b0;
        e_left = 0; e_addr = '0; e_prev = '0; e_prev_v = 0;
        for (int i = 0; i < 4; i++) begin chan_of[i] = '0; exp_chan[i] = '0; end
        for (int c = 0; c < 8; c++) adc_val[c] = 8'($urandom);
        adc_val[2] = 8'hA5;

        vecs[0] = '{4'b1111, 12'o7521, 4, 16'h3210, 5};
        vecs[1] = '{4'b0101, 12'o0603, 2, 16'h0020, 3};
        vecs[2] = '{4'b0011, 12'o0042, 2, 16'h0010, 3};
        vecs[3] = '{4'b1010, 12'o5010, 2, 16'h0013, 3};
        vecs[4] = '{4'b0110, 12'o0730, 2, 16'h0012, 3};
        vecs[5] = '{4'b1000, 12'o2000, 1, 16'h0003, 2};

        #2 rst = 1'b1;
        tick(); tick();
        check("reset_outputs", {8'b0, req_ready, rsp_valid, eng_start, eng_addr, rsp_data, rsp_chan, err_timeout}, 0);
        rst = 1'b0;
        tick();

        // Single request: first frame is discarded, a flush frame returns the result.
        g0 = grant_log.size(); r0 = n_rsp; f0 = n_frames; fl0 = n_flush;
        set_chan(2'd1, 3'd2); req_valid[1] = 1'b1; upd_elig();
        drain(200);
        check("single_grant", qat(grant_log, g0), 1);
        check("single_frames", n_frames - f0, 2);
        check("single_flushes", n_flush - fl0, 1);
        check("single_flush_addr", 32'(last_flush_addr), 2);
        check("single_rsp_count", n_rsp - r0, 1);
        check("single_rsp_data", 32'(last_rsp_data), 32'h A5);
        check("single_rsp_chan", 32'(last_rsp_chan), 2);
        check("single_rsp_owner", qat(rsp_log, rsp_log.size() - 1), 1);

        // Reset in the middle of a frame: the frame is abandoned and no response appears.
        hold_done = 1'b1;
        g0 = grant_log.size(); r0 = n_rsp;
        set_chan(2'd2, 3'd5); req_valid[2] = 1'b1; upd_elig();
        g = 0;
        while (grant_log.size() == g0 && g < 100) begin tick(); g++; end
        check("midwait_granted", grant_log.size() - g0, 1);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("midwait_reset_outputs", {8'b0, req_ready, rsp_valid, eng_start, eng_addr, rsp_data, rsp_chan, err_timeout}, 0);
        n_dropped += $countones(outstanding);
        outstanding = 4'b0; req_valid = 4'b0; mdl_ptr = 2'd0; hold_done = 1'b0; upd_elig();
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midwait_no_rsp", n_rsp - r0, 0);

        // Table of simultaneous request sets, checking round-robin order and frame count.
        for (int v = 0; v < 6; v++) begin
            g0 = grant_log.size(); r0 = rsp_log.size(); f0 = n_frames;
            for (int i = 0; i < 4; i++) begin
                if (vecs[v].mask[i[1:0]]) begin
                    set_chan(i[1:0], 3'(vecs[v].chans >> (3 * i)));
                    req_valid[i[1:0]] = 1'b1;
                end
            end
            upd_elig();
            drain(400);
            for (int k = 0; k < vecs[v].n; k++) begin
                check($sformatf("vec%0d_grant%0d", v, k), qat(grant_log, g0 + k), 32'(4'(vecs[v].order >> (4 * k))));
                check($sformatf("vec%0d_rsp%0d", v, k), qat(rsp_log, r0 + k), 32'(4'(vecs[v].order >> (4 * k))));
            end
            check($sformatf("vec%0d_frames", v), n_frames - f0, vecs[v].frames);
        end

        // Back-to-back: two requesters keep the pipeline full, so no flush until they stop.
        r0 = n_rsp; f0 = n_frames; fl0 = n_flush;
        cont_mask = 4'b0011; cont_mode = 1; drive();
        g = 0;
        while (n_frames - f0 < 12 && g < 1000) begin tick(); g++; end
        check("b2b_frames", n_frames - f0, 12);
        check("b2b_no_flush", n_flush - fl0, 0);
        check("b2b_rsp_per_done", n_rsp - r0, 10);
        cont_mode = 0;
        drain(400);
        check("b2b_drain_flush", n_flush - fl0, 1);
        check("b2b_total_rsp", n_rsp - r0, n_frames - f0 - 1);

        // eng_done while idle is ignored.
        r0 = n_rsp;
        tick();
        eng_done = 1'b1; eng_rdata = 8'h5A;
        for (int i = 0; i < 5; i++) tick();
        check("stray_done_ignored", n_rsp - r0, 0);

        // Randomized traffic against the scoreboard.
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) tick();
        rand_mode = 0;
        drain(2000);
        check("random_no_timeout", n_err, 0);

`ifdef ADC_SCHED_TIMEOUT_EN
        hold_done = 1'b1;
        r0 = n_rsp; g0 = grant_log.size();
        set_chan(2'd3, 3'd1); req_valid[3] = 1'b1; upd_elig();
        g = 0;
        while (grant_log.size() == g0 && g < 100) begin tick(); g++; end
        g = 0;
        while (n_err == 0 && g < 200) begin tick(); g++; end
        check("timeout_cycle", g, 50);
        tick();
        check("timeout_pulse_width", 32'(err_timeout), 0);
        hold_done = 1'b0;
        set_chan(2'd0, 3'd4); req_valid[0] = 1'b1; upd_elig();
        drain(400);
        check("timeout_recover_rsp", n_rsp - r0, 1);
        check("timeout_recover_owner", qat(rsp_log, rsp_log.size() - 1), 0);
`endif

        check("grants_balanced", grant_log.size(), rsp_log.size() + n_dropped);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
